cordic_sweep_ctrl: RTL

Sequencer that drives the frequency and waveform-select inputs of the CORDIC waveform generator. Software or a host loads a byte-wide configuration. On `start`, the block steps the 13-bit frequency word from a start value toward a stop value, holding each value for a programmable dwell time. It supports one-shot, restart-loop and ping-pong-loop modes, with optional waveform cycling at sweep endpoints. It sits between the pin-level configuration inputs and the generator's `freq` / `waveform_sel` ports.

---
 rtl/cordic_sweep_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cordic_sweep_ctrl.sv
// Frequency/waveform sweep sequencer for the CORDIC waveform generator.
// Steps freq_out from start_f toward stop_f with a programmable dwell per value.
module cordic_sweep_ctrl #(
  parameter int FREQ_W  = 13,
  parameter int DWELL_W = 18
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic              stop,
  output logic [FREQ_W-1:0] freq_out,
  output logic [1:0]        waveform_out,
  output logic              busy,
  output logic              tick,
  output logic              sweep_done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_d;
  logic [FREQ_W-1:0]  cfg_start, cfg_stop;
  logic [7:0]         cfg_step, cfg_dwell;
  logic [4:0]         cfg_mode;

  logic [FREQ_W-1:0]  sh_start, sh_stop;
  logic [7:0]         sh_step, sh_dwell;
  logic               sh_loop, sh_pp, sh_wc;

  logic [DWELL_W-1:0] cnt, cnt_d;
  logic               dir, dir_d;          // 0 = up, 1 = down
  logic [FREQ_W-1:0]  freq_d;
  logic [1:0]         wave_d;
  logic               tick_d, done_d, load;

  logic [FREQ_W:0]    step_ext, up_sum, dn_lim;
  logic [FREQ_W-1:0]  up_nxt, dn_nxt;
  logic               up_end, dn_end;

  // Config registers: writable any time, only sampled into shadows on start.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      cfg_start <= '0;
      cfg_stop  <= '0;
      cfg_step  <= '0;
      cfg_dwell <= '0;
      cfg_mode  <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        3'd0: cfg_start[7:0]        <= wr_data;
        3'd1: cfg_start[FREQ_W-1:8] <= wr_data[FREQ_W-9:0];
        3'd2: cfg_stop[7:0]         <= wr_data;
        3'd3: cfg_stop[FREQ_W-1:8]  <= wr_data[FREQ_W-9:0];
        3'd4: cfg_step              <= wr_data;
        3'd5: cfg_dwell             <= wr_data;
        3'd6: cfg_mode              <= wr_data[4:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      sh_start <= '0;
      sh_stop  <= '0;
      sh_step  <= 8'd1;
      sh_dwell <= '0;
      sh_loop  <= 1'b0;
      sh_pp    <= 1'b0;
      sh_wc    <= 1'b0;
    end else if (load) begin
      sh_start <= cfg_start;
      sh_stop  <= cfg_stop;
      sh_step  <= (cfg_step == 8'd0) ? 8'd1 : cfg_step;
      sh_dwell <= cfg_dwell;
      sh_loop  <= cfg_mode[2];
      sh_pp    <= cfg_mode[3] & cfg_mode[2];
      sh_wc    <= cfg_mode[4] & cfg_mode[2];
    end
  end

  // Next-value candidates, one extra bit so neither direction can wrap.
  always_comb begin
    step_ext = {{(FREQ_W-7){1'b0}}, sh_step};
    up_end   = freq_out >= sh_stop;
    up_sum   = {1'b0, freq_out} + step_ext;
    up_nxt   = (up_sum > {1'b0, sh_stop}) ? sh_stop : up_sum[FREQ_W-1:0];
    dn_end   = freq_out <= sh_start;
    dn_lim   = {1'b0, sh_start} + step_ext;
    dn_nxt   = ({1'b0, freq_out} < dn_lim) ? sh_start
                                           : freq_out - step_ext[FREQ_W-1:0];
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    dir_d   = dir;
    freq_d  = freq_out;
    wave_d  = waveform_out;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          load    = 1'b1;
          cnt_d   = {cfg_dwell, {(DWELL_W-8){1'b1}}};
          dir_d   = 1'b0;
          freq_d  = cfg_start;
          wave_d  = cfg_mode[1:0];
          tick_d  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          cnt_d = {sh_dwell, {(DWELL_W-8){1'b1}}};
          if (!(dir ? dn_end : up_end)) begin
            freq_d = dir ? dn_nxt : up_nxt;
            tick_d = 1'b1;
          end else if (!sh_loop) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            tick_d = 1'b1;
            if (sh_wc) wave_d = waveform_out + 2'd1;
            if (!sh_pp) begin
              freq_d = sh_start;
              dir_d  = 1'b0;
            end else begin
              // Reverse, then apply the new direction's rule; a degenerate
              // range is an endpoint both ways and simply holds the value.
              dir_d  = ~dir;
              freq_d = dir ? (up_end ? freq_out : up_nxt)
                           : (dn_end ? freq_out : dn_nxt);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      dir          <= 1'b0;
      freq_out     <= '0;
      waveform_out <= '0;
      tick         <= 1'b0;
      sweep_done   <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      dir          <= dir_d;
      freq_out     <= freq_d;
      waveform_out <= wave_d;
      tick         <= tick_d;
      sweep_done   <= done_d;
    end
  end

  assign busy = (state == RUN);

endmodule
